// File: rtl/bp_reg_mem_if.sv
// Byte-pipe channel between a byte-stream transport and bp_reg_mem.
//   i_bp_data/i_bp_valid/o_bp_ready : host-to-device command/data bytes
//   o_bp_data/o_bp_valid/i_bp_ready : device-to-host response bytes
// Signal names are taken from the device's point of view.
interface bp_reg_mem_if;
  logic [7:0] i_bp_data;
  logic       i_bp_valid;
  logic       o_bp_ready;
  logic [7:0] o_bp_data;
  logic       o_bp_valid;
  logic       i_bp_ready;

  modport slave (
    input  i_bp_data, i_bp_valid, i_bp_ready,
    output o_bp_ready, o_bp_data, o_bp_valid
  );

  modport master (
    output i_bp_data, i_bp_valid, i_bp_ready,
    input  o_bp_ready, o_bp_data, o_bp_valid
  );
endinterface

// File: rtl/bp_reg_mem.sv
// Bank of N_REG 8-bit registers reachable over a byte-pipe channel.
// Command byte: bit7 = write(1)/read(0), bits6:0 = register address.
// A write is followed by one data byte. Each command yields one response
// byte: the register value for a read, the pre-write value for a write,
// 8'h00 for any out-of-range address (writes to those are dropped).
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset, clears registers and FSM
//   i_cg    : clock-gate enable, 0 freezes all state and blocks handshakes
//   bp      : byte-pipe channel (slave side)
module bp_reg_mem #(
  parameter int N_REG = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_cg,
  bp_reg_mem_if.slave   bp
);

  localparam int         AW    = (N_REG > 1) ? $clog2(N_REG) : 1;
  localparam logic [7:0] NREG8 = 8'(N_REG);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t     state;
  logic [6:0] wAddr;
  logic [7:0] rspData;
  logic [7:0] regs [N_REG];

  logic [6:0] rdAddr;
  logic       inRange;
  logic [7:0] rdVal;

  // One read port serves both the read command (address on the bus) and
  // the pre-write lookup (latched address), since they never overlap.
  always_comb begin
    rdAddr  = (state == WDATA) ? wAddr : bp.i_bp_data[6:0];
    inRange = ({1'b0, rdAddr} < NREG8);
    rdVal   = inRange ? regs[rdAddr[AW-1:0]] : '0;
  end

  // Ready is held low during reset even though the FSM sits in IDLE.
  assign bp.o_bp_ready = i_cg && i_rst_n && (state != RESP);
  assign bp.o_bp_valid = (state == RESP);
  assign bp.o_bp_data  = rspData;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      wAddr   <= '0;
      rspData <= '0;
      regs    <= '{default: '0};
    end else if (i_cg) begin
      unique case (state)
        IDLE: begin
          if (bp.i_bp_valid) begin
            if (bp.i_bp_data[7]) begin
              wAddr <= bp.i_bp_data[6:0];
              state <= WDATA;
            end else begin
              rspData <= rdVal;
              state   <= RESP;
            end
          end
        end
        WDATA: begin
          if (bp.i_bp_valid) begin
            rspData <= rdVal;
            if (inRange) regs[wAddr[AW-1:0]] <= bp.i_bp_data;
            state <= RESP;
          end
        end
        RESP: begin
          if (bp.i_bp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_reg_mem.sv
module tb_bp_reg_mem;
  localparam int N_REG = 2;

  logic clk = 1'b0;
  logic rstN;
  logic cg;

  int tests = 0;
  int fails = 0;

  logic [7:0] mReg [N_REG];

  bp_reg_mem_if bpIf ();

  bp_reg_mem #(.N_REG(N_REG)) dut (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .i_cg    (cg),
    .bp      (bpIf.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle protocol checks, sampled 1 time unit after each rising edge.
  logic       prevValid = 1'b0;
  logic [7:0] prevData  = 8'h00;
  always @(posedge clk) begin
    #1;
    if (!rstN) begin
      chk("rstReady", bpIf.o_bp_ready, 0);
      chk("rstValid", bpIf.o_bp_valid, 0);
      chk("rstData", bpIf.o_bp_data, 0);
      prevValid = 1'b0;
    end else begin
      chk("readyRule", bpIf.o_bp_ready, int'(cg && !bpIf.o_bp_valid));
      if (prevValid && !(bpIf.i_bp_ready && cg)) begin
        chk("holdValid", bpIf.o_bp_valid, 1);
        chk("holdData", bpIf.o_bp_data, prevData);
      end
      prevValid = bpIf.o_bp_valid;
      prevData  = bpIf.o_bp_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic setCg(input bit rnd);
    if (rnd) cg = ($urandom_range(0, 4) != 0);
    else     cg = 1'b1;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit rnd);
    int guard = 0;
    @(negedge clk);
    bpIf.i_bp_ready = 1'b0;
    bpIf.i_bp_data  = b;
    bpIf.i_bp_valid = 1'b1;
    setCg(rnd);
    #1;
    while (!bpIf.o_bp_ready && guard < 100) begin
      @(negedge clk);
      setCg(rnd);
      #1;
      guard++;
    end
    if (!bpIf.o_bp_ready) chk("sendTimeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic getResp(input bit rnd, input int hold, output logic [7:0] r);
    int guard = 0;
    @(negedge clk);
    bpIf.i_bp_valid = 1'b0;
    bpIf.i_bp_ready = 1'b0;
    chk("latency", bpIf.o_bp_valid, 1);
    r = bpIf.o_bp_data;
    repeat (hold) begin
      @(negedge clk);
      setCg(rnd);
    end
    @(negedge clk);
    bpIf.i_bp_ready = 1'b1;
    setCg(rnd);
    while (!cg && guard < 100) begin
      @(negedge clk);
      setCg(rnd);
      guard++;
    end
    cg = 1'b1;
    @(posedge clk);
  endtask

  task automatic txn(input logic [7:0] cmd, input logic [7:0] wd, input bit rnd,
                     input int hold, output logic [7:0] r);
    int a;
    logic [7:0] exp;
    a   = int'(cmd[6:0]);
    exp = (a < N_REG) ? mReg[a] : 8'h00;
    sendByte(cmd, rnd);
    if (cmd[7]) sendByte(wd, rnd);
    getResp(rnd, hold, r);
    chk($sformatf("resp cmd=%02h", cmd), r, exp);
    if (cmd[7] && a < N_REG) mReg[a] = wd;
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] r0;
    logic [7:0] c;
    rstN = 1'b1;
    cg   = 1'b1;
    bpIf.i_bp_data  = 8'h00;
    bpIf.i_bp_valid = 1'b0;
    bpIf.i_bp_ready = 1'b0;
    foreach (mReg[i]) mReg[i] = 8'h00;
    #1 rstN = 1'b0;
    repeat (3) @(negedge clk);
    chk("resetReady", bpIf.o_bp_ready, 0);
    chk("resetValid", bpIf.o_bp_valid, 0);
    chk("resetData", bpIf.o_bp_data, 0);
    rstN = 1'b1;
    #1 chk("postResetReady", bpIf.o_bp_ready, 1);

    // Directed sequence with hand-computed expectations.
    txn(8'h00, 8'h00, 0, 0, r); chk("lit read0", r, 8'h00);
    txn(8'h81, 8'h5A, 0, 0, r); chk("lit wr1 5A", r, 8'h00);
    txn(8'h01, 8'h00, 0, 0, r); chk("lit rd1 5A", r, 8'h5A);
    txn(8'h81, 8'hC3, 0, 0, r); chk("lit wr1 C3", r, 8'h5A);
    txn(8'h01, 8'h00, 0, 0, r); chk("lit rd1 C3", r, 8'hC3);
    txn(8'h85, 8'hFF, 0, 0, r); chk("lit oorWr", r, 8'h00);
    txn(8'h05, 8'h00, 0, 0, r); chk("lit oorRd", r, 8'h00);
    txn(8'h00, 8'h00, 0, 0, r); chk("lit rd0 after oor", r, 8'h00);
    txn(8'h01, 8'h00, 0, 0, r); chk("lit rd1 after oor", r, 8'hC3);

    // Backpressure: response held for 10 cycles while a new command waits.
    sendByte(8'h01, 0);
    @(negedge clk);
    bpIf.i_bp_data  = 8'h00;
    bpIf.i_bp_valid = 1'b1;
    bpIf.i_bp_ready = 1'b0;
    chk("bpLatency", bpIf.o_bp_valid, 1);
    r0 = bpIf.o_bp_data;
    chk("lit bpResp", r0, 8'hC3);
    repeat (10) begin
      @(negedge clk);
      chk("bpValid", bpIf.o_bp_valid, 1);
      chk("bpData", bpIf.o_bp_data, r0);
      chk("bpReady", bpIf.o_bp_ready, 0);
    end
    bpIf.i_bp_valid = 1'b0;
    bpIf.i_bp_ready = 1'b1;
    @(negedge clk);
    chk("bpReleased", bpIf.o_bp_valid, 0);
    bpIf.i_bp_ready = 1'b0;
    txn(8'h01, 8'h00, 0, 0, r); chk("lit afterBp", r, 8'hC3);

    // Clock gate held low mid-write: nothing may advance.
    sendByte(8'h81, 0);
    @(negedge clk);
    cg = 1'b0;
    bpIf.i_bp_data  = 8'h77;
    bpIf.i_bp_valid = 1'b1;
    repeat (5) begin
      #1;
      chk("cgReady", bpIf.o_bp_ready, 0);
      chk("cgValid", bpIf.o_bp_valid, 0);
      @(negedge clk);
    end
    sendByte(8'h77, 0);
    getResp(0, 0, r);
    chk("lit cgWrResp", r, 8'hC3);
    mReg[1] = 8'h77;
    txn(8'h01, 8'h00, 0, 0, r); chk("lit cgRd", r, 8'h77);

    // Reset between a write command and its data byte.
    sendByte(8'h81, 0);
    @(negedge clk);
    bpIf.i_bp_valid = 1'b0;
    rstN = 1'b0;
    #1;
    chk("midRstReady", bpIf.o_bp_ready, 0);
    chk("midRstValid", bpIf.o_bp_valid, 0);
    chk("midRstData", bpIf.o_bp_data, 0);
    @(negedge clk);
    rstN = 1'b1;
    foreach (mReg[i]) mReg[i] = 8'h00;
    txn(8'h01, 8'h00, 0, 0, r); chk("lit rd1 afterRst", r, 8'h00);
    txn(8'h00, 8'h00, 0, 0, r); chk("lit rd0 afterRst", r, 8'h00);

    // Randomized traffic with gating and backpressure.
    for (int unsigned n = 0; n < 300; n++) begin
      c[7]   = 1'($urandom_range(0, 1));
      c[6:0] = ($urandom_range(0, 9) == 0) ? 7'h7F : 7'($urandom_range(0, 5));
      txn(c, 8'($urandom), 1, int'($urandom_range(0, 3)), r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
